// File: rtl/uart_rx_sipo_buf.sv
// uart_rx_sipo_buf: serial-in/parallel-out deserialiser for the UART receive path.
//
// Takes one sampled bit per shift strobe from the RX bit-sampling FSM and assembles a
// DATA_W-bit word in the selected bit order. Each completed word moves into a one-entry
// holding register that the consumer drains with a valid/ready handshake. A word that
// completes while the holding register is full and not being popped is dropped, and the
// sticky overrun flag is raised.
//
// Optional feature macro: UART_SIPO_PARITY_EN
//   defined   - each frame is DATA_W data bits followed by one parity bit; parity_err is
//               registered with data_out (even parity when PARITY_ODD=0, odd when 1).
//   undefined - each frame is DATA_W bits and parity_err is tied to 0.
//
// Parameters:
//   DATA_W     data bits per frame (5..16)
//   LSB_FIRST  1: first received bit lands in bit 0; 0: first bit lands in bit DATA_W-1
//   PARITY_ODD parity sense when the parity feature is compiled in
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   bit_in       sampled serial bit
//   shift_en     strobe: capture bit_in this cycle
//   frame_start  abort/restart: clears the shift register and bit counter (wins over shift_en)
//   out_ready    consumer accepts data_out this cycle
//   clr_ovr      clear the sticky overrun flag (a coincident new overrun wins)
//   data_out     holding-register word
//   out_valid    holding register is full
//   overrun      sticky: a completed word was dropped
//   parity_err   parity error for the word in data_out
//   bit_count    bits captured so far in the current frame

module uart_rx_sipo_buf #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_in,
  input  logic                          shift_en,
  input  logic                          frame_start,
  input  logic                          out_ready,
  input  logic                          clr_ovr,
  output logic [DATA_W-1:0]             data_out,
  output logic                          out_valid,
  output logic                          overrun,
  output logic                          parity_err,
  output logic [$clog2(DATA_W+2)-1:0]   bit_count
);

  localparam int unsigned CntW = $clog2(DATA_W + 2);

`ifdef UART_SIPO_PARITY_EN
  localparam int unsigned FrameLen = DATA_W + 1;
`else
  localparam int unsigned FrameLen = DATA_W;
`endif

  localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  // ---------------------------------------------------------------------------
  // Shift path
  // ---------------------------------------------------------------------------
  logic              accept;    // strobe that actually captures a bit
  logic              last;      // accepted strobe that completes the frame
  logic [DATA_W-1:0] shifted;   // sreg with bit_in shifted in
  logic [DATA_W-1:0] word;      // completed data word

  assign accept = shift_en & ~frame_start;
  assign last   = accept & (cnt_q == LastIdx);

  always_comb begin
    shifted = sreg_q;
    if (LSB_FIRST) begin
      shifted = {bit_in, sreg_q[DATA_W-1:1]};
    end else begin
      shifted = {sreg_q[DATA_W-2:0], bit_in};
    end
  end

`ifdef UART_SIPO_PARITY_EN
  // The final strobe carries the parity bit; the data word is already complete in sreg.
  assign word = sreg_q;
`else
  assign word = shifted;
`endif

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (frame_start) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
`ifdef UART_SIPO_PARITY_EN
      // The parity bit is never shifted into the data register.
      sreg_d = last ? sreg_q : shifted;
`else
      sreg_d = shifted;
`endif
      cnt_d  = last ? '0 : cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------
  logic load;   // completed word enters the holding register
  logic drop;   // completed word lost because the holding register is busy

  assign load = last & (~valid_q | out_ready);
  assign drop = last & valid_q & ~out_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Set has priority over clear so a coincident drop is never hidden.
  assign ovr_d = drop | (ovr_q & ~clr_ovr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Parity
  // ---------------------------------------------------------------------------
`ifdef UART_SIPO_PARITY_EN
  logic perr_q, perr_d;
  logic perr_calc;

  // bit_in is the parity bit on the completing strobe.
  assign perr_calc = (^{sreg_q, bit_in}) ^ PARITY_ODD;

  always_comb begin
    perr_d = perr_q;
    if (load) begin
      perr_d = perr_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  // Constant 0; PARITY_ODD is referenced only so the parameter is not reported unused.
  assign parity_err = PARITY_ODD & 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_uart_rx_sipo_buf.sv
// Self-checking bench for uart_rx_sipo_buf. Three instances share all inputs:
// LSB-first/even, MSB-first/even and LSB-first/odd. A table of frames is streamed with the
// consumer always ready; hand-written sequences cover overrun, pop-with-load, frame_start,
// idle strobes and asynchronous reset. Expected words are pushed to a scoreboard queue on the
// completing strobe and popped when the holding register loads.

module tb_uart_rx_sipo_buf;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = $clog2(DW + 2);
`ifdef UART_SIPO_PARITY_EN
  localparam bit          ParEn = 1'b1;
  localparam int unsigned N     = DW + 1;
`else
  localparam bit          ParEn = 1'b0;
  localparam int unsigned N     = DW;
`endif

  logic clk = 1'b0;
  logic rst, bit_in, shift_en, frame_start, out_ready, clr_ovr;

  logic [DW-1:0] lsb_data, msb_data, odd_data;
  logic          lsb_valid, msb_valid, odd_valid;
  logic          lsb_ovr, msb_ovr, odd_ovr;
  logic          lsb_perr, msb_perr, odd_perr;
  logic [CW-1:0] lsb_cnt, msb_cnt, odd_cnt;

  always #5 clk = ~clk;

  uart_rx_sipo_buf #(.DATA_W(DW), .LSB_FIRST(1'b1), .PARITY_ODD(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .shift_en(shift_en), .frame_start(frame_start),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .data_out(lsb_data), .out_valid(lsb_valid),
    .overrun(lsb_ovr), .parity_err(lsb_perr), .bit_count(lsb_cnt)
  );

  uart_rx_sipo_buf #(.DATA_W(DW), .LSB_FIRST(1'b0), .PARITY_ODD(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .shift_en(shift_en), .frame_start(frame_start),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .data_out(msb_data), .out_valid(msb_valid),
    .overrun(msb_ovr), .parity_err(msb_perr), .bit_count(msb_cnt)
  );

  uart_rx_sipo_buf #(.DATA_W(DW), .LSB_FIRST(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .shift_en(shift_en), .frame_start(frame_start),
    .out_ready(out_ready), .clr_ovr(clr_ovr), .data_out(odd_data), .out_valid(odd_valid),
    .overrun(odd_ovr), .parity_err(odd_perr), .bit_count(odd_cnt)
  );

  // Frame table: word is transmitted bit 0 first.
  typedef struct {
    logic [7:0] word;
    logic       par;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
    logic       exp_even;
    logic       exp_odd;
  } vec_t;

  typedef struct {
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       pe;
    logic       po;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] l, input logic [7:0] m,
                              input logic pe, input logic po);
    exp_t e;
    e.lsb = l;
    e.msb = m;
    e.pe  = ParEn ? pe : 1'b0;
    e.po  = ParEn ? po : 1'b0;
    return e;
  endfunction

  // Pops the scoreboard when the holding register has just loaded.
  task automatic check_load(input string name);
    exp_t e;
    check({name, "_valid"}, {lsb_valid, msb_valid, odd_valid}, 3'b111);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got empty scoreboard, expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_lsb"}, lsb_data, e.lsb);
      check({name, "_msb"}, msb_data, e.msb);
      check({name, "_odd"}, odd_data, e.lsb);
      check({name, "_pe"}, lsb_perr, e.pe);
      check({name, "_po"}, odd_perr, e.po);
    end
  endtask

  // Sends one full frame; bit_count is checked after every strobe.
  task automatic send_frame(input string name, input logic [7:0] w, input logic p,
                            input bit expect_load, input logic rdy_body,
                            input logic rdy_last, input logic clr_last, input exp_t e);
    for (int i = 0; i < N; i++) begin
      bit_in    = (i < DW) ? w[i] : p;
      shift_en  = 1'b1;
      out_ready = (i == N - 1) ? rdy_last : rdy_body;
      clr_ovr   = (i == N - 1) ? clr_last : 1'b0;
      if (i == N - 1 && expect_load) sb_q.push_back(e);
      tick();
      check({name, "_cnt"}, {lsb_cnt, msb_cnt},
            (i == N - 1) ? 16'd0 : {CW'(i + 1), CW'(i + 1)});
    end
    shift_en  = 1'b0;
    clr_ovr   = 1'b0;
    out_ready = rdy_body;
    if (expect_load) check_load(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h4B, 1'b0, 8'h4B, 8'hD2, 1'b0, 1'b1};
    vecs[1] = '{8'h4B, 1'b1, 8'h4B, 8'hD2, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 8'h11, 8'h88, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hC8, 1'b0, 8'hC8, 8'h13, 1'b1, 1'b0};

    rst = 1'b1; bit_in = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clr_ovr = 1'b0;
    #1;
    check("rst_data", {lsb_data, msb_data}, 16'h0000);
    check("rst_valid", {lsb_valid, msb_valid, odd_valid}, 3'b000);
    check("rst_ovr", {lsb_ovr, msb_ovr, odd_ovr}, 3'b000);
    check("rst_perr", {lsb_perr, msb_perr, odd_perr}, 3'b000);
    check("rst_cnt", {lsb_cnt, msb_cnt}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Streaming frames, consumer always ready.
    for (int v = 0; v < 7; v++) begin
      send_frame($sformatf("vec%0d", v), vecs[v].word, vecs[v].par, 1'b1, 1'b1, 1'b1, 1'b0,
                 mk(vecs[v].exp_lsb, vecs[v].exp_msb, vecs[v].exp_even, vecs[v].exp_odd));
      check($sformatf("vec%0d_ovr", v), lsb_ovr, 1'b0);
    end

    // Pop with no completion empties the holding register; data holds.
    out_ready = 1'b1;
    tick();
    check("pop_valid", {lsb_valid, msb_valid}, 2'b00);
    check("pop_hold", lsb_data, 8'hC8);

    // Overrun: consumer stalled, second frame is dropped.
    send_frame("ovr_a", 8'h4B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(8'h4B, 8'hD2, 1'b0, 1'b1));
    check("ovr_a_ovr", lsb_ovr, 1'b0);
    send_frame("ovr_b", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(8'h00, 8'h00, 1'b0, 1'b0));
    check("ovr_b_data", {lsb_data, msb_data}, 16'h4BD2);
    check("ovr_b_valid", lsb_valid, 1'b1);
    check("ovr_b_ovr", {lsb_ovr, msb_ovr, odd_ovr}, 3'b111);
    check("ovr_b_perr", {lsb_perr, odd_perr}, ParEn ? 2'b01 : 2'b00);
    // clr_ovr coincident with a fresh drop: set wins.
    send_frame("ovr_c", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'h00, 8'h00, 1'b0, 1'b0));
    check("ovr_c_ovr", lsb_ovr, 1'b1);
    check("ovr_c_data", lsb_data, 8'h4B);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("clr_ovr", {lsb_ovr, msb_ovr}, 2'b00);
    tick();
    check("clr_stays", lsb_ovr, 1'b0);

    // Pop and completion in the same cycle: new word loads, no overrun.
    send_frame("popld", 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, mk(8'h11, 8'h88, 1'b1, 1'b0));
    check("popld_ovr", lsb_ovr, 1'b0);

    // frame_start beats a coincident strobe and leaves the holding register alone.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_in = 1'b1; shift_en = 1'b1;
      tick();
    end
    check("fs_pre_cnt", lsb_cnt, 4'd4);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; shift_en = 1'b0;
    check("fs_cnt", {lsb_cnt, msb_cnt}, 16'd0);
    check("fs_valid", lsb_valid, 1'b1);
    check("fs_data", {lsb_data, msb_data}, 16'h1188);

    // Idle cycles without shift_en leave the count alone.
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b0; shift_en = 1'b1;
      tick();
    end
    shift_en = 1'b0; bit_in = 1'b1;
    tick();
    tick();
    check("idle_cnt", lsb_cnt, 4'd3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs2_cnt", lsb_cnt, 4'd0);

    out_ready = 1'b1;
    tick();
    check("pop2_valid", lsb_valid, 1'b0);
    check("pop2_hold", lsb_data, 8'h11);
    send_frame("post_fs", 8'h4B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, mk(8'h4B, 8'hD2, 1'b1, 1'b0));

    // Asynchronous reset mid-frame.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b1; shift_en = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", {lsb_data, msb_data}, 16'h0000);
    check("arst_valid", {lsb_valid, msb_valid, odd_valid}, 3'b000);
    check("arst_ovr", lsb_ovr, 1'b0);
    check("arst_perr", {lsb_perr, odd_perr}, 2'b00);
    check("arst_cnt", {lsb_cnt, msb_cnt}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_frame("post_rst", 8'hC8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, mk(8'hC8, 8'h13, 1'b1, 1'b0));

    check("sb_empty", sb_q.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
